// File: rtl/bit_pattern_pkg.sv
// bit_pattern_pkg: shared FSM state type and default pattern-detector configuration
package bit_pattern_pkg;

    typedef enum logic {ST_FILL, ST_ARMED} state_e;

    localparam int         DEF_PAT_LEN = 4;
    localparam logic [3:0] DEF_PATTERN = 4'b1011;
    localparam int         DEF_CNT_W   = 8;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones and can be flushed synchronously
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    // Next count: flush wins, otherwise step unless already pinned at the top.
    always_comb begin
        count_d = clr ? '0 : (inc && count_q != '1) ? count_q + WIDTH'(1) : count_q;
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/bit_pattern_detector.sv
// bit_pattern_detector: overlapping serial pattern matcher with armed flag and saturating match count; BIT_PATTERN_DETECTOR_FIRST_EN adds first-match beat capture
module bit_pattern_detector
    import bit_pattern_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN),
    parameter int                 CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear,
    output logic             match,
    output logic             armed,
    output logic [CNT_W-1:0] match_count
`ifdef BIT_PATTERN_DETECTOR_FIRST_EN
    ,
    output logic [15:0]      first_match_idx,
    output logic             first_seen
`endif
);

    localparam int FW = $clog2(PAT_LEN + 1);

    state_e             state_q, state_d;
    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic               match_q, match_d;
    logic               beat;

    // History shift, fill tracking and match detection; a beat during clear is dropped.
    always_comb begin
        beat    = in_valid && !clear;
        hist_d  = hist_q;
        fill_d  = fill_q;
        state_d = state_q;
        match_d = 1'b0;
        if (clear) begin
            hist_d  = '0;
            fill_d  = '0;
            state_d = ST_FILL;
        end else if (in_valid) begin
            hist_d = {hist_q[PAT_LEN-2:0], in_bit};
            if (state_q == ST_FILL) begin
                fill_d = fill_q + FW'(1);
                if (fill_q == FW'(PAT_LEN - 1)) state_d = ST_ARMED;
            end
            match_d = (state_q == ST_ARMED || fill_q == FW'(PAT_LEN - 1)) && hist_d == PATTERN;
        end
    end

    // State, history and match pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FILL;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (match_d),
        .count (match_count)
    );

    assign match = match_q;
    assign armed = state_q == ST_ARMED;

`ifdef BIT_PATTERN_DETECTOR_FIRST_EN
    logic [15:0] beat_idx;
    logic [15:0] first_idx_q, first_idx_d;
    logic        first_seen_q, first_seen_d;

    sat_counter #(.WIDTH(16)) u_beat_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (beat),
        .count (beat_idx)
    );

    // Capture the index of the beat completing the first match; hold until flushed.
    always_comb begin
        first_idx_d  = clear ? '0 : (match_d && !first_seen_q) ? beat_idx : first_idx_q;
        first_seen_d = clear ? 1'b0 : first_seen_q || match_d;
    end

    // First-match capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_idx_q  <= '0;
            first_seen_q <= 1'b0;
        end else begin
            first_idx_q  <= first_idx_d;
            first_seen_q <= first_seen_d;
        end
    end

    assign first_match_idx = first_idx_q;
    assign first_seen      = first_seen_q;
`endif

endmodule
